// File: rtl/pipeline_defs.sv
// Shared pipeline encodings: forwarding selects, hazard FSM states, decoder opcodes.
package pipeline_defs;

  localparam int unsigned FWD_W   = 2;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned OPC_W   = 7;

  // E-stage operand source selects
  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  // Data-memory wait sequencer states
  typedef enum logic [STATE_W-1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } hz_state_e;

  // Major opcodes shared with the main decoder
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/forwarding_unit.sv
// Selects the E-stage source for one operand: M result beats W result beats regfile.
module forwarding_unit
  import pipeline_defs::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  output logic [FWD_W-1:0]  fwd_sel_o
);

  // x0 is never forwarded; the younger (M) producer has priority
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (rs_e_i != '0) begin
      if (reg_write_m_i && (rd_m_i == rs_e_i)) begin
        fwd_sel_o = FWD_MEM;
      end else if (reg_write_w_i && (rd_w_i == rs_e_i)) begin
        fwd_sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencing, E-stage forwarding and dmem wait/timeout for the 5-stage pipeline.
module pipeline_hazard_controller
  import pipeline_defs::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              result_src_e0,
  input  logic              pc_src_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_req_m,
  input  logic              dmem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              stall_w,
  output logic              flush_d,
  output logic              flush_e,
  output logic [FWD_W-1:0]  fwd_a_e,
  output logic [FWD_W-1:0]  fwd_b_e,
  output logic              dmem_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  hz_state_e           state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic [FWD_W-1:0]    fwd_a_raw, fwd_b_raw;
  logic                mem_hold_c;
  logic                load_use_c;

  forwarding_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e_i        (rs1_e),
    .rd_m_i        (rd_m),
    .rd_w_i        (rd_w),
    .reg_write_m_i (reg_write_m),
    .reg_write_w_i (reg_write_w),
    .fwd_sel_o     (fwd_a_raw)
  );

  forwarding_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e_i        (rs2_e),
    .rd_m_i        (rd_m),
    .rd_w_i        (rd_w),
    .reg_write_m_i (reg_write_m),
    .reg_write_w_i (reg_write_w),
    .fwd_sel_o     (fwd_b_raw)
  );

  // Hazard detection: pipeline freeze for dmem, and load-use against the D operands
  always_comb begin
    mem_hold_c = 1'b0;
    load_use_c = 1'b0;
    unique case (state_q)
      ST_RUN:  mem_hold_c = mem_req_m && !dmem_ready;
      ST_WAIT: mem_hold_c = !dmem_ready;
      ST_ERR:  mem_hold_c = 1'b1;
      default: mem_hold_c = 1'b0;
    endcase
    load_use_c = result_src_e0 && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  end

  // Priority: dmem freeze defers everything, then taken branch, then load-use bubble
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    stall_w = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (rst_n) begin
      fwd_a_e = fwd_a_raw;
      fwd_b_e = fwd_b_raw;
      if (mem_hold_c) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        stall_w = 1'b1;
      end else if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use_c) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Next state for the dmem wait sequencer and the stall performance counter
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_req_m && !dmem_ready) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
          state_d   = ST_ERR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dmem_timeout = timeout_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed table, dmem wait/timeout sequences, randomized run vs reference model.
module tb_pipeline_hazard_controller;

  localparam int unsigned TB_MAX_WAIT = 4;
  localparam int unsigned TB_CNT_W    = 6;
  localparam int          CNT_MAX     = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       ld_e, pc_src, rw_m, rw_w, mem_req, ready;
  } in_t;

  // {sf, sd, se, sm, sw, fd, fe, fwd_a[1:0], fwd_b[1:0]}
  typedef logic [10:0] ctl_t;

  typedef struct {
    in_t  i;
    ctl_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic result_src_e0, pc_src_e, reg_write_m, reg_write_w, mem_req_m, dmem_ready;
  logic stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic dmem_timeout;
  logic [TB_CNT_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  bit m_err;
  int m_miss;      // consecutive not-ready cycles of the outstanding access (0 = none)
  int m_cnt;
  bit m_timeout;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .REG_AW(5), .MAX_WAIT(TB_MAX_WAIT), .WAIT_W(8), .CNT_W(TB_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .result_src_e0(result_src_e0), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_req_m(mem_req_m), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .dmem_timeout(dmem_timeout), .stall_cnt(stall_cnt)
  );

  function automatic in_t mk(input int r1d, r2d, r1e, r2e, rde, rdm, rdw,
                             input bit ld, pc, rwm, rww);
    in_t x;
    x.rs1_d = 5'(r1d); x.rs2_d = 5'(r2d); x.rs1_e = 5'(r1e); x.rs2_e = 5'(r2e);
    x.rd_e = 5'(rde); x.rd_m = 5'(rdm); x.rd_w = 5'(rdw);
    x.ld_e = ld; x.pc_src = pc; x.rw_m = rwm; x.rw_w = rww;
    x.mem_req = 1'b0; x.ready = 1'b1;
    return x;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t x);
    if (rs == 5'd0) return 2'b00;
    if (x.rw_m && x.rd_m == rs) return 2'b10;
    if (x.rw_w && x.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic ctl_t ref_ctl(input in_t x);
    bit hold, lu;
    logic [6:0] s;
    if (m_err) hold = 1;
    else if (m_miss > 0) hold = !x.ready;
    else hold = x.mem_req && !x.ready;
    lu = x.ld_e && (x.rd_e != 0) && (x.rd_e == x.rs1_d || x.rd_e == x.rs2_d);
    if (hold) s = 7'b1111100;
    else if (x.pc_src) s = 7'b0000011;
    else if (lu) s = 7'b1100001;
    else s = 7'b0000000;
    return {s, ref_fwd(x.rs1_e, x), ref_fwd(x.rs2_e, x)};
  endfunction

  task automatic model_reset();
    m_err = 0; m_miss = 0; m_cnt = 0; m_timeout = 0;
  endtask

  task automatic model_advance(input in_t x, input ctl_t e);
    if (e[10] && m_cnt < CNT_MAX) m_cnt++;
    if (m_err) begin
    end else if (m_miss > 0) begin
      if (x.ready) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss == TB_MAX_WAIT + 1) begin m_err = 1; m_timeout = 1; end
      end
    end else if (x.mem_req && !x.ready) begin
      m_miss = 1;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t dut_ctl();
    return {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, fwd_a_e, fwd_b_e};
  endfunction

  task automatic drive(input in_t x);
    rs1_d = x.rs1_d; rs2_d = x.rs2_d; rs1_e = x.rs1_e; rs2_e = x.rs2_e;
    rd_e = x.rd_e; rd_m = x.rd_m; rd_w = x.rd_w;
    result_src_e0 = x.ld_e; pc_src_e = x.pc_src;
    reg_write_m = x.rw_m; reg_write_w = x.rw_w;
    mem_req_m = x.mem_req; dmem_ready = x.ready;
  endtask

  // Apply one cycle: compare at negedge, advance model after posedge
  task automatic cycle(input in_t x, input ctl_t exp, input string name);
    drive(x);
    @(negedge clk);
    check({name, ".ctl"}, 16'(dut_ctl()), 16'(exp));
    check({name, ".cnt"}, 16'(stall_cnt), 16'(m_cnt));
    check({name, ".tmo"}, 16'(dmem_timeout), 16'(m_timeout));
    @(posedge clk);
    model_advance(x, exp);
    #1;
  endtask

  task automatic mcycle(input in_t x, input string name);
    cycle(x, ref_ctl(x), name);
  endtask

  task automatic reset_pulse(input in_t x, input string name);
    drive(x);
    rst_n = 1'b0;
    #1;
    check({name, ".rst_ctl"}, 16'(dut_ctl()), 16'd0);
    check({name, ".rst_cnt"}, 16'(stall_cnt), 16'd0);
    check({name, ".rst_tmo"}, 16'(dmem_timeout), 16'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl[11];

  initial begin
    in_t x;
    in_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{mk(5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0), {7'b1100001, 2'b00, 2'b00}};
    tbl[1]  = '{mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {7'b0000000, 2'b00, 2'b00}};
    tbl[2]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), {7'b0000000, 2'b00, 2'b00}};
    tbl[3]  = '{mk(1, 5, 0, 0, 5, 0, 0, 1, 0, 0, 0), {7'b1100001, 2'b00, 2'b00}};
    tbl[4]  = '{mk(5, 0, 0, 0, 5, 0, 0, 1, 1, 0, 0), {7'b0000011, 2'b00, 2'b00}};
    tbl[5]  = '{mk(0, 0, 7, 0, 0, 7, 7, 0, 0, 1, 1), {7'b0000000, 2'b10, 2'b00}};
    tbl[6]  = '{mk(0, 0, 7, 0, 0, 7, 7, 0, 0, 0, 1), {7'b0000000, 2'b01, 2'b00}};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), {7'b0000000, 2'b00, 2'b00}};
    tbl[8]  = '{mk(0, 0, 9, 9, 0, 9, 9, 0, 0, 0, 1), {7'b0000000, 2'b01, 2'b01}};
    tbl[9]  = '{mk(5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0), {7'b0000000, 2'b00, 2'b00}};
    tbl[10] = '{mk(0, 0, 3, 4, 0, 4, 3, 0, 0, 1, 0), {7'b0000000, 2'b00, 2'b10}};

    // Reset with a load-use and a dmem miss on the inputs: everything must read 0
    x = mk(5, 0, 7, 0, 5, 7, 0, 1, 1, 1, 0);
    x.mem_req = 1'b1; x.ready = 1'b0;
    drive(x);
    rst_n = 1'b0;
    model_reset();
    #12;
    check("reset.ctl", 16'(dut_ctl()), 16'd0);
    check("reset.cnt", 16'(stall_cnt), 16'd0);
    check("reset.tmo", 16'(dmem_timeout), 16'd0);
    drive(z);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed combinational table
    for (int k = 0; k < 11; k++) begin
      cycle(tbl[k].i, tbl[k].e, $sformatf("tbl%0d", k));
    end

    // dmem miss for 3 cycles with a taken branch pending, then ready
    x = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    x.mem_req = 1'b1; x.ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle(x, 11'b11111000000, $sformatf("wait%0d", k));
    x.ready = 1'b1;
    cycle(x, 11'b00000110000, "wait_rel");
    check("wait.cnt3", 16'(stall_cnt), 16'd5);
    cycle(z, 11'b0, "after_rel");

    // Never-ready access: ERR after MAX_WAIT wait cycles, sticky, ignores ready
    x = z; x.mem_req = 1'b1; x.ready = 1'b0;
    for (int k = 0; k <= int'(TB_MAX_WAIT); k++) mcycle(x, $sformatf("tmo%0d", k));
    check("tmo.flag", 16'(dmem_timeout), 16'd1);
    for (int k = 0; k < 70; k++) begin
      x.ready = k[0];
      x.mem_req = k[1];
      cycle(x, {7'b1111100, 4'b0000}, "err_hold");
    end
    check("cnt.sat", 16'(stall_cnt), 16'(CNT_MAX));
    @(negedge clk);
    reset_pulse(x, "err_rst");
    #1;
    check("post_rst.ctl", 16'(dut_ctl()), 16'd0);
    @(posedge clk); #1;
    x = z; x.ready = 1'b0;
    cycle(x, 11'b0, "run_after_rst");

    // Randomized run against the reference model
    for (int k = 0; k < 3000; k++) begin
      x.rs1_d = 5'($urandom_range(0, 7)); x.rs2_d = 5'($urandom_range(0, 7));
      x.rs1_e = 5'($urandom_range(0, 7)); x.rs2_e = 5'($urandom_range(0, 7));
      x.rd_e  = 5'($urandom_range(0, 7)); x.rd_m  = 5'($urandom_range(0, 7));
      x.rd_w  = 5'($urandom_range(0, 7));
      x.ld_e = 1'($urandom_range(0, 1)); x.pc_src = 1'($urandom_range(0, 3) == 0);
      x.rw_m = 1'($urandom_range(0, 1)); x.rw_w = 1'($urandom_range(0, 1));
      x.mem_req = 1'($urandom_range(0, 3) == 0); x.ready = 1'($urandom_range(0, 3) != 0);
      mcycle(x, "rnd");
      if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
        reset_pulse(x, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
